mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_if.sv | 28 ++
 rtl/mem_port_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Memory-side bus of the fetch/data port arbiter: one outstanding access,
// completed by mem_ready with read data returned alongside it.
interface mem_port_arbiter_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ready,
        output mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single memory port between instruction fetch and the data stage.
// Data wins on contention; a stuck access is aborted after TIMEOUT wait cycles.
module mem_port_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      reset_x,
    input  logic                      Fi_req,
    input  logic [31:0]               Fi_addr,
    input  logic                      Fi_kill,
    input  logic                      Mi_req,
    input  logic                      Mi_we,
    input  logic [31:0]               Mi_addr,
    input  logic [31:0]               Mi_wdata,
    mem_port_arbiter_if.master        mem,
    output logic [31:0]               Fo_instr,
    output logic                      Fo_valid,
    output logic                      Fo_stall,
    output logic [31:0]               Mo_rdata,
    output logic                      Mo_valid,
    output logic                      Mo_stall,
    output logic                      o_timeoutErr
);

    localparam logic [7:0]  TIMEOUT_C = TIMEOUT[7:0];
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IFETCH  = 2'd1,
        DACCESS = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        kill_q, kill_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] fo_instr_q, fo_instr_d;
    logic        fo_valid_q, fo_valid_d;
    logic [31:0] mo_rdata_q, mo_rdata_d;
    logic        mo_valid_q, mo_valid_d;
    logic        err_q, err_d;

    logic fetch_pend;
    logic data_pend;
    logic kill_now;
    logic timeout_hit;

    // A requester whose valid is pulsing this cycle has just been served.
    assign fetch_pend  = Fi_req & ~fo_valid_q;
    assign data_pend   = Mi_req & ~mo_valid_q;
    assign kill_now    = kill_q | Fi_kill;
    assign timeout_hit = (cnt_q + 8'd1) == TIMEOUT_C;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        kill_d     = kill_q;
        mem_req_d  = mem_req_q;
        mem_we_d   = mem_we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        fo_instr_d = fo_instr_q;
        fo_valid_d = 1'b0;
        mo_rdata_d = mo_rdata_q;
        mo_valid_d = 1'b0;
        err_d      = err_q;

        case (state_q)
            IDLE: begin
                kill_d = 1'b0;
                if (data_pend) begin
                    state_d   = DACCESS;
                    cnt_d     = 8'd0;
                    mem_req_d = 1'b1;
                    mem_we_d  = Mi_we;
                    addr_d    = Mi_addr;
                    wdata_d   = Mi_wdata;
                end else if (fetch_pend) begin
                    state_d   = IFETCH;
                    cnt_d     = 8'd0;
                    mem_req_d = 1'b1;
                    mem_we_d  = 1'b0;
                    addr_d    = Fi_addr;
                end
            end

            IFETCH: begin
                kill_d = kill_now;
                if (mem.mem_ready || timeout_hit) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    kill_d    = 1'b0;
                    err_d     = err_q | ~mem.mem_ready;
                    if (!kill_now) begin
                        fo_valid_d = 1'b1;
                        fo_instr_d = mem.mem_ready ? mem.mem_rdata : NOP_INSTR;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            DACCESS: begin
                if (mem.mem_ready) begin
                    state_d    = IDLE;
                    mem_req_d  = 1'b0;
                    mem_we_d   = 1'b0;
                    mo_valid_d = 1'b1;
                    if (!mem_we_q) begin
                        mo_rdata_d = mem.mem_rdata;
                    end
                end else if (timeout_hit) begin
                    state_d    = IDLE;
                    mem_req_d  = 1'b0;
                    mem_we_d   = 1'b0;
                    mo_valid_d = 1'b1;
                    mo_rdata_d = 32'h0;
                    err_d      = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_x) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            kill_q     <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            fo_instr_q <= 32'h0;
            fo_valid_q <= 1'b0;
            mo_rdata_q <= 32'h0;
            mo_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            kill_q     <= kill_d;
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            fo_instr_q <= fo_instr_d;
            fo_valid_q <= fo_valid_d;
            mo_rdata_q <= mo_rdata_d;
            mo_valid_q <= mo_valid_d;
            err_q      <= err_d;
        end
    end

    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;

    assign Fo_instr     = fo_instr_q;
    assign Fo_valid     = fo_valid_q;
    assign Mo_rdata     = mo_rdata_q;
    assign Mo_valid     = mo_valid_q;
    assign o_timeoutErr = err_q;
    assign Fo_stall     = Fi_req & ~fo_valid_q;
    assign Mo_stall     = Mi_req & ~mo_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: contention, store, fetch kill,
// timeout abort and mid-access reset, with hand-computed expectations.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset_x;
    logic        Fi_req;
    logic [31:0] Fi_addr;
    logic        Fi_kill;
    logic        Mi_req;
    logic        Mi_we;
    logic [31:0] Mi_addr;
    logic [31:0] Mi_wdata;
    logic [31:0] Fo_instr;
    logic        Fo_valid;
    logic        Fo_stall;
    logic [31:0] Mo_rdata;
    logic        Mo_valid;
    logic        Mo_stall;
    logic        o_timeoutErr;

    int n_checks = 0;
    int n_fail   = 0;

    mem_port_arbiter_if mem_bus ();

    mem_port_arbiter #(.TIMEOUT(4)) dut (
        .clk          (clk),
        .reset_x      (reset_x),
        .Fi_req       (Fi_req),
        .Fi_addr      (Fi_addr),
        .Fi_kill      (Fi_kill),
        .Mi_req       (Mi_req),
        .Mi_we        (Mi_we),
        .Mi_addr      (Mi_addr),
        .Mi_wdata     (Mi_wdata),
        .mem          (mem_bus),
        .Fo_instr     (Fo_instr),
        .Fo_valid     (Fo_valid),
        .Fo_stall     (Fo_stall),
        .Mo_rdata     (Mo_rdata),
        .Mo_valid     (Mo_valid),
        .Mo_stall     (Mo_stall),
        .o_timeoutErr (o_timeoutErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_x  = 1'b1;
        Fi_req   = 1'b0;
        Fi_addr  = 32'h0;
        Fi_kill  = 1'b0;
        Mi_req   = 1'b0;
        Mi_we    = 1'b0;
        Mi_addr  = 32'h0;
        Mi_wdata = 32'h0;
        mem_bus.mem_ready = 1'b0;
        mem_bus.mem_rdata = 32'h0;
        tick();
        tick();

        // Reset state
        check("rst_mem_req",  {31'h0, mem_bus.mem_req}, 32'h0);
        check("rst_fo_valid", {31'h0, Fo_valid}, 32'h0);
        check("rst_mo_valid", {31'h0, Mo_valid}, 32'h0);
        check("rst_err",      {31'h0, o_timeoutErr}, 32'h0);
        check("rst_fo_instr", Fo_instr, 32'h0);
        reset_x = 1'b0;
        tick();
        $display("txn reset done");

        // mem_ready outside an access is ignored
        mem_bus.mem_ready = 1'b1;
        mem_bus.mem_rdata = 32'hFFFF_FFFF;
        tick();
        check("idle_ready_mo_valid", {31'h0, Mo_valid}, 32'h0);
        check("idle_ready_fo_valid", {31'h0, Fo_valid}, 32'h0);
        check("idle_ready_mem_req",  {31'h0, mem_bus.mem_req}, 32'h0);
        mem_bus.mem_ready = 1'b0;
        tick();
        $display("txn idle mem_ready ignored");

        // Simultaneous fetch and load: data first
        Fi_req  = 1'b1;
        Fi_addr = 32'h300;
        Mi_req  = 1'b1;
        Mi_we   = 1'b0;
        Mi_addr = 32'h100;
        #1;
        check("sim_fo_stall0", {31'h0, Fo_stall}, 32'h1);
        check("sim_mo_stall0", {31'h0, Mo_stall}, 32'h1);
        check("sim_mem_req0",  {31'h0, mem_bus.mem_req}, 32'h0);
        tick();
        check("sim_mem_req1",  {31'h0, mem_bus.mem_req}, 32'h1);
        check("sim_mem_addr1", mem_bus.mem_addr, 32'h100);
        check("sim_mem_we1",   {31'h0, mem_bus.mem_we}, 32'h0);
        tick();
        check("sim_mem_req2",  {31'h0, mem_bus.mem_req}, 32'h1);
        check("sim_fo_stall2", {31'h0, Fo_stall}, 32'h1);
        mem_bus.mem_ready = 1'b1;
        mem_bus.mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_bus.mem_ready = 1'b0;
        check("sim_mo_valid",  {31'h0, Mo_valid}, 32'h1);
        check("sim_mo_rdata",  Mo_rdata, 32'hDEAD_BEEF);
        check("sim_mem_req3",  {31'h0, mem_bus.mem_req}, 32'h0);
        check("sim_mo_stall3", {31'h0, Mo_stall}, 32'h0);
        check("sim_fo_stall3", {31'h0, Fo_stall}, 32'h1);
        check("sim_fo_valid3", {31'h0, Fo_valid}, 32'h0);
        Mi_req = 1'b0;
        tick();
        check("sim_mo_valid_drop", {31'h0, Mo_valid}, 32'h0);
        check("sim_if_mem_req",    {31'h0, mem_bus.mem_req}, 32'h1);
        check("sim_if_mem_addr",   mem_bus.mem_addr, 32'h300);
        check("sim_if_mem_we",     {31'h0, mem_bus.mem_we}, 32'h0);
        check("sim_if_fo_stall",   {31'h0, Fo_stall}, 32'h1);
        mem_bus.mem_ready = 1'b1;
        mem_bus.mem_rdata = 32'h0050_0093;
        tick();
        mem_bus.mem_ready = 1'b0;
        check("sim_fo_valid",  {31'h0, Fo_valid}, 32'h1);
        check("sim_fo_instr",  Fo_instr, 32'h0050_0093);
        check("sim_fo_stall5", {31'h0, Fo_stall}, 32'h0);
        check("sim_mem_req5",  {31'h0, mem_bus.mem_req}, 32'h0);
        check("sim_mo_rdata5", Mo_rdata, 32'hDEAD_BEEF);
        Fi_req = 1'b0;
        tick();
        check("sim_fo_valid_drop", {31'h0, Fo_valid}, 32'h0);
        $display("txn load 0x100 then fetch 0x300");

        // Store with immediate ready
        Mi_req   = 1'b1;
        Mi_we    = 1'b1;
        Mi_addr  = 32'h200;
        Mi_wdata = 32'h1234_5678;
        tick();
        check("st_mem_req",   {31'h0, mem_bus.mem_req}, 32'h1);
        check("st_mem_we",    {31'h0, mem_bus.mem_we}, 32'h1);
        check("st_mem_addr",  mem_bus.mem_addr, 32'h200);
        check("st_mem_wdata", mem_bus.mem_wdata, 32'h1234_5678);
        mem_bus.mem_ready = 1'b1;
        mem_bus.mem_rdata = 32'hAAAA_5555;
        tick();
        mem_bus.mem_ready = 1'b0;
        check("st_mem_we_drop",  {31'h0, mem_bus.mem_we}, 32'h0);
        check("st_mem_req_drop", {31'h0, mem_bus.mem_req}, 32'h0);
        check("st_mo_valid",     {31'h0, Mo_valid}, 32'h1);
        check("st_mo_rdata",     Mo_rdata, 32'hDEAD_BEEF);
        Mi_req = 1'b0;
        Mi_we  = 1'b0;
        tick();
        check("st_mo_valid_drop", {31'h0, Mo_valid}, 32'h0);
        check("st_mem_we_idle",   {31'h0, mem_bus.mem_we}, 32'h0);
        $display("txn store 0x200 <= 0x12345678");

        // Fetch killed while waiting, then a clean refetch
        Fi_req  = 1'b1;
        Fi_addr = 32'h40;
        tick();
        check("kill_mem_req",  {31'h0, mem_bus.mem_req}, 32'h1);
        check("kill_mem_addr", mem_bus.mem_addr, 32'h40);
        Fi_kill = 1'b1;
        tick();
        Fi_kill = 1'b0;
        Fi_addr = 32'h80;
        #1;
        check("kill_fo_valid1",  {31'h0, Fo_valid}, 32'h0);
        check("kill_addr_held",  mem_bus.mem_addr, 32'h40);
        mem_bus.mem_ready = 1'b1;
        mem_bus.mem_rdata = 32'h0000_0BAD;
        tick();
        mem_bus.mem_ready = 1'b0;
        check("kill_fo_valid2", {31'h0, Fo_valid}, 32'h0);
        check("kill_fo_instr",  Fo_instr, 32'h0050_0093);
        check("kill_mem_req2",  {31'h0, mem_bus.mem_req}, 32'h0);
        tick();
        check("refetch_mem_req",  {31'h0, mem_bus.mem_req}, 32'h1);
        check("refetch_mem_addr", mem_bus.mem_addr, 32'h80);
        check("refetch_fo_valid", {31'h0, Fo_valid}, 32'h0);
        mem_bus.mem_ready = 1'b1;
        mem_bus.mem_rdata = 32'h1357_9BDF;
        tick();
        mem_bus.mem_ready = 1'b0;
        check("refetch_fo_valid2", {31'h0, Fo_valid}, 32'h1);
        check("refetch_fo_instr",  Fo_instr, 32'h1357_9BDF);
        check("refetch_err",       {31'h0, o_timeoutErr}, 32'h0);
        Fi_req = 1'b0;
        tick();
        $display("txn fetch 0x40 killed, refetch 0x80");

        // Fetch timeout with TIMEOUT=4
        Fi_req  = 1'b1;
        Fi_addr = 32'h500;
        tick();
        check("to_mem_req1", {31'h0, mem_bus.mem_req}, 32'h1);
        tick();
        tick();
        tick();
        check("to_mem_req4",  {31'h0, mem_bus.mem_req}, 32'h1);
        check("to_fo_valid4", {31'h0, Fo_valid}, 32'h0);
        check("to_err4",      {31'h0, o_timeoutErr}, 32'h0);
        tick();
        check("to_fo_valid", {31'h0, Fo_valid}, 32'h1);
        check("to_fo_instr", Fo_instr, 32'h0000_0013);
        check("to_err",      {31'h0, o_timeoutErr}, 32'h1);
        check("to_mem_req",  {31'h0, mem_bus.mem_req}, 32'h0);
        Fi_req = 1'b0;
        tick();
        tick();
        check("to_err_sticky",  {31'h0, o_timeoutErr}, 32'h1);
        check("to_fo_valid_dn", {31'h0, Fo_valid}, 32'h0);
        $display("txn fetch 0x500 timed out");

        // Reset mid-DACCESS, held request reissued afterwards
        Mi_req  = 1'b1;
        Mi_we   = 1'b0;
        Mi_addr = 32'h600;
        tick();
        check("rd_mem_req", {31'h0, mem_bus.mem_req}, 32'h1);
        tick();
        reset_x = 1'b1;
        mem_bus.mem_ready = 1'b1;
        mem_bus.mem_rdata = 32'h0000_0077;
        tick();
        reset_x = 1'b0;
        mem_bus.mem_ready = 1'b0;
        check("rd_mem_req_rst",  {31'h0, mem_bus.mem_req}, 32'h0);
        check("rd_mo_valid_rst", {31'h0, Mo_valid}, 32'h0);
        check("rd_mo_rdata_rst", Mo_rdata, 32'h0);
        check("rd_err_rst",      {31'h0, o_timeoutErr}, 32'h0);
        check("rd_addr_rst",     mem_bus.mem_addr, 32'h0);
        check("rd_instr_rst",    Fo_instr, 32'h0);
        tick();
        check("rd_reissue_req",  {31'h0, mem_bus.mem_req}, 32'h1);
        check("rd_reissue_addr", mem_bus.mem_addr, 32'h600);
        mem_bus.mem_ready = 1'b1;
        mem_bus.mem_rdata = 32'h0BAD_F00D;
        tick();
        mem_bus.mem_ready = 1'b0;
        check("rd_mo_valid", {31'h0, Mo_valid}, 32'h1);
        check("rd_mo_rdata", Mo_rdata, 32'h0BAD_F00D);
        Mi_req = 1'b0;
        tick();
        check("rd_mo_valid_dn", {31'h0, Mo_valid}, 32'h0);
        $display("txn reset mid-load, reissue 0x600");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
